// File: rtl/replay_pkg.sv
// ---------------------------------------------------------------------------
// replay_pkg
// Shared types and defaults for the signal replayer.
//   DEF_DATA_W / DEF_TIME_W : default event data and timestamp widths
//   replay_event_t          : one change event {ev_time, ev_data}
//   replay_state_t          : playback FSM encoding (IDLE=0, PLAYING=1)
// ---------------------------------------------------------------------------
package replay_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_TIME_W = 32;

    typedef struct packed {
        logic [DEF_TIME_W-1:0] ev_time;
        logic [DEF_DATA_W-1:0] ev_data;
    } replay_event_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } replay_state_t;

endpackage

// File: rtl/signal_replayer_if.sv
// ---------------------------------------------------------------------------
// signal_replayer_if
// Event streaming handshake between the host command path and the replayer.
//   event_valid : host offers an event
//   event_ready : replayer buffer has room
//   event_time  : timestamp of the offered event (clk ticks from playback start)
//   event_data  : value data_out takes at that timestamp
// Modports: master = host side, slave = replayer side.
// ---------------------------------------------------------------------------
interface signal_replayer_if
    import replay_pkg::*;
#(
    parameter int TIME_W = DEF_TIME_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              event_valid;
    logic              event_ready;
    logic [TIME_W-1:0] event_time;
    logic [DATA_W-1:0] event_data;

    modport master (
        output event_valid,
        output event_time,
        output event_data,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_time,
        input  event_data,
        output event_ready
    );
endinterface

// File: rtl/replay_event_fifo.sv
// ---------------------------------------------------------------------------
// replay_event_fifo
// Synchronous FIFO of timestamped events with flush.
//   clk, rst            : clock, synchronous active-low reset
//   push, push_time/data: write an event (ignored when full)
//   pop                 : drop the head (ignored when empty)
//   flush               : discard all contents; overrides push and pop
//   full, empty         : occupancy flags
//   head_time/head_data : oldest stored event (valid when !empty)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A pushed entry only becomes visible at the head after the write edge.
// ---------------------------------------------------------------------------
module replay_event_fifo #(
    parameter int TIME_W = 32,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [TIME_W-1:0] push_time,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [TIME_W-1:0] head_time,
    output logic [DATA_W-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [TIME_W+DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign {head_time, head_data} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr[AW-1:0]] <= {push_time, push_data};
    end
endmodule

// File: rtl/signal_replayer.sv
// ---------------------------------------------------------------------------
// signal_replayer
// Rebuilds a waveform from timestamped change events: events are buffered,
// and during playback each one is driven onto data_out once the playback
// time counter reaches its timestamp (late events are applied at once).
//   clk, rst  : clock, synchronous active-low reset
//   start     : begin / restart playback (time counter back to 0)
//   stop      : abort playback, flush the buffer; wins over start
//   evt       : event handshake (slave modport of signal_replayer_if)
//   data_out  : reconstructed signal (registered)
//   playing   : high while in PLAYING
//   late      : sticky late-event flag, present only when
//               REPLAYER_LATE_FLAG_EN is defined; cleared by reset or start
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | events accepted and held, data_out and tcount frozen
// PLAYING | tcount advances, due head events are applied one per cycle
// ---------------------------------------------------------------------------
module signal_replayer
    import replay_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TIME_W     = DEF_TIME_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    signal_replayer_if.slave  evt,
    output logic [DATA_W-1:0] data_out,
`ifdef REPLAYER_LATE_FLAG_EN
    output logic              playing,
    output logic              late
`else
    output logic              playing
`endif
);
    replay_state_t     state;
    logic [TIME_W-1:0] tcount;
    logic              fifo_full;
    logic              fifo_empty;
    logic [TIME_W-1:0] head_time;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              pop;

    assign evt.event_ready = !fifo_full;
    assign push = evt.event_valid && !fifo_full && !stop;

    // A restart edge pops nothing so the fresh timeline keeps the
    // start -> T+1 latency for every event still queued.
    assign pop = (state == PLAYING) && !fifo_empty && (head_time <= tcount)
                 && !stop && !start;

    replay_event_fifo #(
        .TIME_W (TIME_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_time (evt.event_time),
        .push_data (evt.event_data),
        .pop       (pop),
        .flush     (stop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_time (head_time),
        .head_data (head_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tcount   <= '0;
            data_out <= '0;
            playing  <= 1'b0;
`ifdef REPLAYER_LATE_FLAG_EN
            late     <= 1'b0;
`endif
        end else if (stop) begin
            state   <= IDLE;
            playing <= 1'b0;
        end else if (start) begin
            state   <= PLAYING;
            playing <= 1'b1;
            tcount  <= '0;
`ifdef REPLAYER_LATE_FLAG_EN
            late    <= 1'b0;
`endif
        end else if (state == PLAYING) begin
            if (tcount != '1) tcount <= tcount + TIME_W'(1);
            if (pop) begin
                data_out <= head_data;
`ifdef REPLAYER_LATE_FLAG_EN
                if (head_time < tcount) late <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_signal_replayer.sv
module tb_signal_replayer;
    import replay_pkg::*;

    localparam int DATA_W = DEF_DATA_W;
    localparam int TIME_W = DEF_TIME_W;
    localparam int DEPTH  = 8;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              playing;
`ifdef REPLAYER_LATE_FLAG_EN
    logic              late;
`endif

    signal_replayer_if #(.TIME_W(TIME_W), .DATA_W(DATA_W)) evt ();

    signal_replayer #(
        .DATA_W     (DATA_W),
        .TIME_W     (TIME_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .evt      (evt),
        .data_out (data_out),
`ifdef REPLAYER_LATE_FLAG_EN
        .playing  (playing),
        .late     (late)
`else
        .playing  (playing)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] d;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input logic [TIME_W-1:0] t, input logic [DATA_W-1:0] d);
        evt.event_valid = 1'b1;
        evt.event_time  = t;
        evt.event_data  = d;
        tick();
        evt.event_valid = 1'b0;
    endtask

    task automatic expect_at(input int due, input logic [DATA_W-1:0] d);
        exp_t e;
        e.due = due;
        e.d   = d;
        sb.push_back(e);
    endtask

    // Scoreboard: each expected change is checked at the cycle it is due.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("sb_due", 64'(cyc), 64'(e.due));
            chk("sb_data", 64'(data_out), 64'(e.d));
        end
    end

    initial begin
        int s;
        evt.event_valid = 1'b0;
        evt.event_time  = '0;
        evt.event_data  = '0;

        // reset
        rst = 1'b0;
        tick();
        tick();
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_playing", 64'(playing), 64'd0);
        chk("rst_ready", 64'(evt.event_ready), 64'd1);
`ifdef REPLAYER_LATE_FLAG_EN
        chk("rst_late", 64'(late), 64'd0);
`endif
        rst = 1'b1;
        tick();

        // basic replay
        push_evt(0, 8'd69);
        push_evt(3, 8'd100);
        s = cyc + 1;
        expect_at(s + 1, 8'd69);
        expect_at(s + 4, 8'd100);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("basic_playing", 64'(playing), 64'd1);
        end
        chk("basic_data_end", 64'(data_out), 64'd100);
        chk("basic_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop1_playing", 64'(playing), 64'd0);
        chk("stop1_data", 64'(data_out), 64'd100);

        // full buffer
        for (int i = 0; i < DEPTH; i++) begin
            chk("full_ready_pre", 64'(evt.event_ready), 64'd1);
            push_evt(TIME_W'(2 * i), DATA_W'(10 + i));
        end
        chk("full_ready", 64'(evt.event_ready), 64'd0);
        evt.event_valid = 1'b1;
        evt.event_time  = '0;
        evt.event_data  = 8'd99;
        tick();
        evt.event_valid = 1'b0;
        chk("full_ready_held", 64'(evt.event_ready), 64'd0);
        s = cyc + 1;
        for (int i = 0; i < DEPTH; i++) expect_at(s + 2 * i + 1, DATA_W'(10 + i));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("full_ready_after_pop", 64'(evt.event_ready), 64'd1);
        repeat (18) tick();
        chk("full_last_data", 64'(data_out), 64'd17);
        chk("full_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);

        // late event: restart, wait until tcount==10, push (2,5)
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        evt.event_valid = 1'b1;
        evt.event_time  = 2;
        evt.event_data  = 8'd5;
        expect_at(cyc + 2, 8'd5);
        tick();
        evt.event_valid = 1'b0;
`ifdef REPLAYER_LATE_FLAG_EN
        chk("late_before", 64'(late), 64'd0);
`endif
        tick();
        chk("late_data", 64'(data_out), 64'd5);
`ifdef REPLAYER_LATE_FLAG_EN
        chk("late_set", 64'(late), 64'd1);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef REPLAYER_LATE_FLAG_EN
        chk("late_cleared_by_start", 64'(late), 64'd0);
`endif

        // stop with events pending at t=20; concurrent push is dropped
        push_evt(100, 8'd1);
        push_evt(110, 8'd2);
        push_evt(120, 8'd3);
        repeat (17) tick();
        stop = 1'b1;
        evt.event_valid = 1'b1;
        evt.event_time  = 0;
        evt.event_data  = 8'd200;
        tick();
        stop = 1'b0;
        evt.event_valid = 1'b0;
        chk("stop_playing", 64'(playing), 64'd0);
        chk("stop_data_held", 64'(data_out), 64'd5);
        chk("stop_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);
        chk("stop_ready", 64'(evt.event_ready), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("stop_no_replay", 64'(data_out), 64'd5);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", 64'(playing), 64'd0);

        // equal timestamps: one per cycle
        push_evt(5, 8'd7);
        push_evt(5, 8'd8);
        s = cyc + 1;
        expect_at(s + 6, 8'd7);
        expect_at(s + 7, 8'd8);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("eq_last_data", 64'(data_out), 64'd8);

        // reset mid-playback
        push_evt(50, 8'd1);
        push_evt(60, 8'd2);
        chk("mid_playing", 64'(playing), 64'd1);
        rst = 1'b0;
        tick();
        chk("mid_rst_data", 64'(data_out), 64'd0);
        chk("mid_rst_playing", 64'(playing), 64'd0);
        chk("mid_rst_ready", 64'(evt.event_ready), 64'd1);
        chk("mid_rst_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);
        chk("mid_rst_tcount", 64'(dut.tcount), 64'd0);
`ifdef REPLAYER_LATE_FLAG_EN
        chk("mid_rst_late", 64'(late), 64'd0);
`endif
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", 64'(playing), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
